// File: rtl/clock_step_ctrl.sv
// Run/halt/step controller: synchronizes and debounces three buttons and drives a registered clock-enable.
// Button-to-clk_en latency is 2 sync + DEBOUNCE + 1 cycles; every output is a direct flop.
module clock_step_ctrl #(
  parameter int DEBOUNCE = 4,
  parameter int STEP_W   = 8
) (
  input  logic              CP,
  input  logic              reset,
  input  logic              run_btn,
  input  logic              halt_btn,
  input  logic              step_btn,
  input  logic [STEP_W-1:0] step_count,
  output logic              clk_en,
  output logic              running,
  output logic              stepping,
  output logic [STEP_W-1:0] steps_left,
  output logic              step_done
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  // Button order within the vectors: [0]=run, [1]=halt, [2]=step.
  logic [2:0] btn_raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] deb;
  logic [2:0] deb_q;
  logic [2:0] req;
  logic [CNT_W-1:0] db_cnt [3];

  assign btn_raw = {step_btn, halt_btn, run_btn};

  always_ff @(posedge CP) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_q <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_q <= deb;
    end
  end

  for (genvar b = 0; b < 3; b++) begin : g_debounce
    // Level flips only after DEBOUNCE consecutive disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge CP) begin
      if (reset) begin
        deb[b]    <= 1'b0;
        db_cnt[b] <= '0;
      end else if (sync2[b] == deb[b]) begin
        db_cnt[b] <= '0;
      end else if (db_cnt[b] == DB_LAST) begin
        deb[b]    <= sync2[b];
        db_cnt[b] <= '0;
      end else begin
        db_cnt[b] <= db_cnt[b] + 1'b1;
      end
    end
  end

  assign req = deb & ~deb_q;

  state_t            state;
  state_t            state_nx;
  logic [STEP_W-1:0] left_nx;
  logic              done_nx;

  always_comb begin
    state_nx = state;
    left_nx  = steps_left;
    done_nx  = 1'b0;
    unique case (state)
      S_HALT: begin
        if (req[1]) begin
          state_nx = S_HALT;
        end else if (req[2]) begin
          state_nx = S_STEP;
          left_nx  = (step_count == '0) ? STEP_W'(1) : step_count;
        end else if (req[0]) begin
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (req[1]) state_nx = S_HALT;
      end
      S_STEP: begin
        if (req[1]) begin
          state_nx = S_HALT;
          left_nx  = '0;
        end else if (steps_left == STEP_W'(1)) begin
          state_nx = S_HALT;
          left_nx  = '0;
          done_nx  = 1'b1;
        end else begin
          left_nx  = steps_left - 1'b1;
        end
      end
      default: begin
        state_nx = S_HALT;
        left_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge CP) begin
    if (reset) begin
      state      <= S_HALT;
      clk_en     <= 1'b0;
      running    <= 1'b0;
      stepping   <= 1'b0;
      steps_left <= '0;
      step_done  <= 1'b0;
    end else begin
      state      <= state_nx;
      clk_en     <= (state_nx != S_HALT);
      running    <= (state_nx == S_RUN);
      stepping   <= (state_nx == S_STEP);
      steps_left <= left_nx;
      step_done  <= done_nx;
    end
  end

endmodule

// File: doc/clock_step_ctrl.md
CLOCK_STEP_CTRL -- requirements
Module: clock_step_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 4, meaning consecutive CP cycles a synchronized button level must hold before it is accepted (legal range 1..255).
REQ-002 SHALL have parameter STEP_W, default 8, meaning the width of the step count and step counter.
REQ-003 SHALL have port CP  input  1  single system clock; all state updates occur on the CP rising edge only.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port run_btn  input  1  raw asynchronous run button, active high.
REQ-006 SHALL have port halt_btn  input  1  raw asynchronous halt button, active high.
REQ-007 SHALL have port step_btn  input  1  raw asynchronous single/multi-step button, active high.
REQ-008 SHALL have port step_count  input  STEP_W  number of enabled cycles per step request; 0 is treated as 1.
REQ-009 SHALL have port clk_en  output  1  registered clock-enable feeding the downstream pulse generator / clock gate.
REQ-010 SHALL have port running  output  1  high while in state RUN.
REQ-011 SHALL have port stepping  output  1  high while in state STEP.
REQ-012 SHALL have port steps_left  output  STEP_W  remaining enabled cycles in the current step burst.
REQ-013 SHALL have port step_done  output  1  one-cycle pulse when a step burst completes normally.

Function
REQ-014 SHALL pass each raw button through a 2-flop synchronizer before any other use.
REQ-015 SHALL keep one debounced level per button; it changes only after the synchronized level has differed from it for DEBOUNCE consecutive cycles, and the per-button counter clears on any cycle where they agree.
REQ-016 SHALL generate a one-cycle request pulse on each 0->1 transition of a debounced level; no request on 1->0 and none while held.
REQ-017 SHALL implement states HALT, RUN, STEP, with all outputs registered.
REQ-018 SHALL apply request priority halt > step > run when requests coincide in one cycle.
REQ-019 HALT: run request -> RUN; step request -> STEP with steps_left loaded with step_count (1 if step_count==0).
REQ-020 RUN: halt request -> HALT; step and run requests ignored.
REQ-021 STEP: steps_left decrements by 1 per cycle; on the cycle steps_left==1, next state is HALT, steps_left becomes 0, and step_done pulses high for exactly that next cycle.
REQ-022 STEP: halt request -> HALT immediately, steps_left cleared to 0, no step_done; run and step requests ignored.
REQ-023 SHALL drive clk_en high iff state is RUN or STEP, updated on the same edge as the state, so a burst of N gives exactly N consecutive high clk_en cycles.
REQ-024 SHALL change clk_en only on CP rising edges; clk_en SHALL be glitch-free (direct flop output, no combinational path from inputs).
REQ-025 running and stepping SHALL be mutually exclusive and both low in HALT.
REQ-026 SHALL ignore button glitches shorter than DEBOUNCE synchronized cycles.

Reset
REQ-027 reset high on an edge SHALL set state HALT, clk_en 0, running 0, stepping 0, steps_left 0, step_done 0, all synchronizer flops, debounced levels and debounce counters to 0.
REQ-028 reset SHALL override all requests, including mid-burst; no step_done results from an aborted burst.
REQ-029 A button held high through reset release SHALL yield exactly one request after synchronizer plus debounce latency.

Verification
REQ-030 DEBOUNCE=4, run_btn raised and held before edge 1 in HALT -> clk_en and running high after edge 7, low before.
REQ-031 step_count=3, step_btn pressed in HALT -> clk_en high exactly 3 cycles, steps_left 3,2,1 then 0, step_done high one cycle coinciding with clk_en's first low cycle.
REQ-032 step_count=0, step press -> exactly 1 clk_en cycle and one step_done.
REQ-033 run_btn pulse of 2 cycles (DEBOUNCE=4) -> no state change; halt_btn and step_btn debounced on the same cycle in HALT -> remain HALT.
REQ-034 step_count=200, halt press mid-burst -> HALT, steps_left 0, no step_done; reset mid-RUN -> all outputs 0 on next edge.
